// File: rtl/onewire_multi.sv
// onewire_multi: register-mapped 1-wire master that drives one of OWN ports.
//
// A single 32-bit control/status word is exposed on a minimal Avalon-style
// slave port. Writing cyc=1 starts either a reset/presence cycle (128 time
// units) or a single-bit data cycle (8 time units) on the selected port.
//
// Ports:
//   clk                 system clock
//   rst                 synchronous active-high reset
//   avalon_read         register read strobe (clears stx/srx)
//   avalon_write        register write strobe
//   avalon_writedata    write data
//   avalon_readdata     status word (combinational from registers)
//   avalon_waitrequest  always 0
//   avalon_interrupt    (etx & stx) | (erx & srx)
//   owr_e               per-port pull-low enable
//   owr_p               per-port strong pull-up enable
//   owr_i               per-port line level (already synchronised)
module onewire_multi #(
    parameter int OWN   = 1,
    parameter int CDR_N = 7,
    parameter int CDR_O = 1,
    parameter int OWW   = (OWN > 1) ? $clog2(OWN) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           avalon_read,
    input  logic           avalon_write,
    input  logic [31:0]    avalon_writedata,
    output logic [31:0]    avalon_readdata,
    output logic           avalon_waitrequest,
    output logic           avalon_interrupt,
    output logic [OWN-1:0] owr_e,
    output logic [OWN-1:0] owr_p,
    input  logic [OWN-1:0] owr_i
);

    localparam int DIV_MAX = (CDR_N > CDR_O) ? CDR_N : CDR_O;
    localparam int DW      = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;

    // Register fields
    logic           ovd_q, ovd_d;
    logic           rstc_q, rstc_d;   // reset-cycle select field
    logic           dtx_q, dtx_d;
    logic           drx_q, drx_d;
    logic           stx_q, stx_d;
    logic           srx_q, srx_d;
    logic           etx_q, etx_d;
    logic           erx_q, erx_d;
    logic           pwr_q, pwr_d;
    logic [OWW-1:0] sel_q, sel_d;

    // Cycle engine
    logic           busy_q, busy_d;
    logic [DW-1:0]  div_q, div_d;
    logic [6:0]     cnt_q, cnt_d;
    logic           oen_q, oen_d;     // line is being pulled low

    logic [DW-1:0]  unit_m1;
    logic           pls;
    logic           line_in;
    logic           sample;
    logic           unused_wd;

    assign unit_m1 = ovd_q ? DW'(CDR_O - 1) : DW'(CDR_N - 1);
    assign pls     = busy_q && (div_q == unit_m1);

    // Selected line level; an out-of-range select reads as an idle (high) line.
    always_comb begin
        line_in = 1'b1;
        for (int i = 0; i < OWN; i++) begin
            if (sel_q == OWW'(i)) begin
                line_in = owr_i[i];
            end
        end
    end

    always_comb begin
        ovd_d  = ovd_q;
        rstc_d = rstc_q;
        dtx_d  = dtx_q;
        drx_d  = drx_q;
        stx_d  = stx_q;
        srx_d  = srx_q;
        etx_d  = etx_q;
        erx_d  = erx_q;
        pwr_d  = pwr_q;
        sel_d  = sel_q;
        busy_d = busy_q;
        div_d  = div_q;
        cnt_d  = cnt_q;
        oen_d  = oen_q;
        sample = 1'b0;

        // Read-clear goes first so that a set in the same clock wins.
        if (avalon_read) begin
            stx_d = 1'b0;
            srx_d = 1'b0;
        end

        if (avalon_write) begin
            etx_d = avalon_writedata[6];
            erx_d = avalon_writedata[7];
            if (!busy_q) begin
                ovd_d  = avalon_writedata[0];
                rstc_d = avalon_writedata[1];
                dtx_d  = avalon_writedata[2];
                pwr_d  = avalon_writedata[9];
                sel_d  = avalon_writedata[16 +: OWW];
                if (avalon_writedata[8]) begin
                    busy_d = 1'b1;
                    div_d  = '0;
                    cnt_d  = avalon_writedata[1] ? 7'd127 : 7'd7;
                    oen_d  = 1'b1;
                end
            end
        end

        if (busy_q) begin
            if (pls) begin
                div_d = '0;
                cnt_d = cnt_q - 7'd1;
                if (rstc_q) begin
                    if (cnt_q == 7'd64) oen_d = 1'b0;
                    if (cnt_q == 7'd55) sample = 1'b1;
                end else begin
                    // Write-1 releases after one unit, write-0 after seven.
                    if ((dtx_q && cnt_q == 7'd7) || cnt_q == 7'd1) oen_d = 1'b0;
                    if (cnt_q == 7'd6) sample = 1'b1;
                end
                if (cnt_q == 7'd0) begin
                    busy_d = 1'b0;
                    stx_d  = 1'b1;
                    cnt_d  = 7'd0;
                    oen_d  = 1'b0;
                end
            end else begin
                div_d = div_q + DW'(1);
            end
        end

        if (sample) begin
            drx_d = line_in;
            srx_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovd_q  <= 1'b0;
            rstc_q <= 1'b0;
            dtx_q  <= 1'b0;
            drx_q  <= 1'b0;
            stx_q  <= 1'b0;
            srx_q  <= 1'b0;
            etx_q  <= 1'b0;
            erx_q  <= 1'b0;
            pwr_q  <= 1'b0;
            sel_q  <= '0;
            busy_q <= 1'b0;
            div_q  <= '0;
            cnt_q  <= '0;
            oen_q  <= 1'b0;
        end else begin
            ovd_q  <= ovd_d;
            rstc_q <= rstc_d;
            dtx_q  <= dtx_d;
            drx_q  <= drx_d;
            stx_q  <= stx_d;
            srx_q  <= srx_d;
            etx_q  <= etx_d;
            erx_q  <= erx_d;
            pwr_q  <= pwr_d;
            sel_q  <= sel_d;
            busy_q <= busy_d;
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            oen_q  <= oen_d;
        end
    end

    always_comb begin
        avalon_readdata              = '0;
        avalon_readdata[0]           = ovd_q;
        avalon_readdata[1]           = rstc_q;
        avalon_readdata[2]           = dtx_q;
        avalon_readdata[3]           = drx_q;
        avalon_readdata[4]           = stx_q;
        avalon_readdata[5]           = srx_q;
        avalon_readdata[6]           = etx_q;
        avalon_readdata[7]           = erx_q;
        avalon_readdata[9]           = pwr_q;
        avalon_readdata[10]          = busy_q;
        avalon_readdata[16 +: OWW]   = sel_q;
    end

    assign avalon_waitrequest = 1'b0;
    assign avalon_interrupt   = (etx_q & stx_q) | (erx_q & srx_q);

    // Pull-low only while busy and pull-up only while idle, so the two never overlap.
    always_comb begin
        owr_e = '0;
        owr_p = '0;
        for (int i = 0; i < OWN; i++) begin
            if (sel_q == OWW'(i)) begin
                owr_e[i] = oen_q & busy_q;
                owr_p[i] = pwr_q & ~busy_q;
            end
        end
    end

    // Only a subset of the write word is decoded.
    assign unused_wd = ^avalon_writedata;

endmodule

// File: tb/tb_onewire_multi.sv
// tb_onewire_multi: directed self-checking bench for onewire_multi
// (OWN=4, CDR_N=2, CDR_O=1, OWW widened to 3 so sel=5 is representable).
module tb_onewire_multi;

    logic        clk = 1'b0;
    logic        rst;
    logic        avalon_read;
    logic        avalon_write;
    logic [31:0] avalon_writedata;
    logic [31:0] avalon_readdata;
    logic        avalon_waitrequest;
    logic        avalon_interrupt;
    logic [3:0]  owr_e;
    logic [3:0]  owr_p;
    logic [3:0]  owr_i;

    int n_chk  = 0;
    int n_fail = 0;

    int fall;
    int hi;
    int bad;
    int int_e;

    onewire_multi #(
        .OWN   (4),
        .CDR_N (2),
        .CDR_O (1),
        .OWW   (3)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .avalon_read        (avalon_read),
        .avalon_write       (avalon_write),
        .avalon_writedata   (avalon_writedata),
        .avalon_readdata    (avalon_readdata),
        .avalon_waitrequest (avalon_waitrequest),
        .avalon_interrupt   (avalon_interrupt),
        .owr_e              (owr_e),
        .owr_p              (owr_p),
        .owr_i              (owr_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] d);
        avalon_writedata = d;
        avalon_write     = 1'b1;
        tick();
        avalon_write     = 1'b0;
        avalon_writedata = 32'h0;
    endtask

    task automatic rd();
        avalon_read = 1'b1;
        tick();
        avalon_read = 1'b0;
    endtask

    initial begin
        rst              = 1'b1;
        avalon_read      = 1'b0;
        avalon_write     = 1'b0;
        avalon_writedata = 32'h0;
        owr_i            = 4'b0000;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_readdata", avalon_readdata, 32'h0);
        chk("reset_owr_e", 32'(owr_e), 32'h0);
        chk("reset_owr_p", 32'(owr_p), 32'h0);
        chk("reset_irq", 32'(avalon_interrupt), 32'h0);
        chk("waitrequest", 32'(avalon_waitrequest), 32'h0);

        // Data-1 cycle on port 2; line high only across the edge-4 sample.
        wr(32'h0002_0104);                       // edge 0
        chk("d1_e_e0", 32'(owr_e), 32'h4);
        chk("d1_p_e0", 32'(owr_p), 32'h0);
        tick();                                  // edge 1
        chk("d1_e_e1", 32'(owr_e), 32'h4);
        tick();                                  // edge 2
        chk("d1_e_e2", 32'(owr_e), 32'h0);
        tick();                                  // edge 3
        owr_i[2] = 1'b1;
        tick();                                  // edge 4
        owr_i[2] = 1'b0;
        chk("d1_sample_e4", avalon_readdata, 32'h0002_042C);
        fall = -1;
        bad  = 0;
        for (int e = 5; e <= 40; e++) begin
            tick();
            if (owr_e != 4'b0000 || owr_p != 4'b0000) bad++;
            if (fall < 0 && !avalon_readdata[10]) fall = e;
        end
        chk("d1_busy_fall", 32'(fall), 32'd16);
        chk("d1_idle_ports", 32'(bad), 32'd0);
        chk("d1_status", avalon_readdata, 32'h0002_003C);
        rd();
        chk("d1_read_clear", avalon_readdata, 32'h0002_000C);

        // Data-0 cycle on port 0 with the line held low; read lands on the stx-set edge.
        owr_i = 4'b1110;
        wr(32'h0000_0100);                       // edge 0
        hi  = int'(owr_e[0]);
        bad = 0;
        for (int e = 1; e <= 15; e++) begin
            tick();
            hi += int'(owr_e[0]);
            if (owr_e[3:1] != 3'b000) bad++;
        end
        chk("d0_mid_status", avalon_readdata, 32'h0000_0420);
        avalon_read = 1'b1;
        tick();                                  // edge 16
        avalon_read = 1'b0;
        chk("d0_set_wins", avalon_readdata, 32'h0000_0010);
        chk("d0_low_clocks", 32'(hi), 32'd14);
        chk("d0_other_ports", 32'(bad), 32'd0);
        chk("d0_irq", 32'(avalon_interrupt), 32'h0);
        rd();
        chk("d0_read_clear", avalon_readdata, 32'h0);

        // Reset/presence cycle, erx=1, presence pulse only across edge 146.
        owr_i = 4'b1111;
        wr(32'h0000_0182);                       // edge 0
        hi    = int'(owr_e[0]);
        int_e = -1;
        fall  = -1;
        for (int e = 1; e <= 300; e++) begin
            if (e == 146) owr_i[0] = 1'b0;
            tick();
            if (e == 146) owr_i[0] = 1'b1;
            hi += int'(owr_e[0]);
            if (int_e < 0 && avalon_interrupt) int_e = e;
            if (fall < 0 && !avalon_readdata[10]) fall = e;
        end
        chk("rc_low_clocks", 32'(hi), 32'd128);
        chk("rc_irq_edge", 32'(int_e), 32'd146);
        chk("rc_busy_fall", 32'(fall), 32'd256);
        chk("rc_status", avalon_readdata, 32'h0000_00B2);
        chk("rc_irq_end", 32'(avalon_interrupt), 32'h1);
        rd();
        chk("rc_irq_clear", 32'(avalon_interrupt), 32'h0);
        chk("rc_read_clear", avalon_readdata, 32'h0000_0082);

        // Overdrive reset cycle; mid-cycle write may only touch etx/erx.
        wr(32'h0000_0103);                       // edge 0
        for (int e = 1; e <= 9; e++) tick();
        wr(32'h0003_00C0);                       // edge 10
        chk("ovd_midwrite", avalon_readdata, 32'h0000_04C3);
        fall = -1;
        for (int e = 11; e <= 200; e++) begin
            tick();
            if (fall < 0 && !avalon_readdata[10]) fall = e;
        end
        chk("ovd_busy_fall", 32'(fall), 32'd128);
        chk("ovd_status", avalon_readdata, 32'h0000_00FB);
        chk("ovd_irq", 32'(avalon_interrupt), 32'h1);
        rd();
        chk("ovd_read_clear", avalon_readdata, 32'h0000_00CB);
        chk("ovd_irq_clear", 32'(avalon_interrupt), 32'h0);

        // Strong pull-up on port 1, suppressed while a cycle runs.
        wr(32'h0001_0200);
        chk("pwr_p_idle", 32'(owr_p), 32'h2);
        chk("pwr_e_idle", 32'(owr_e), 32'h0);
        wr(32'h0001_0300);                       // edge 0
        chk("pwr_p_busy", 32'(owr_p), 32'h0);
        chk("pwr_e_busy", 32'(owr_e), 32'h2);
        fall = -1;
        bad  = 0;
        for (int e = 1; e <= 40; e++) begin
            tick();
            if (avalon_readdata[10] && owr_p != 4'b0000) bad++;
            if ((owr_e & owr_p) != 4'b0000) bad++;
            if (fall < 0 && !avalon_readdata[10]) fall = e;
        end
        chk("pwr_busy_fall", 32'(fall), 32'd16);
        chk("pwr_overlap", 32'(bad), 32'd0);
        chk("pwr_p_after", 32'(owr_p), 32'h2);
        chk("pwr_status", avalon_readdata, 32'h0001_0238);
        rd();

        // Out-of-range select: timing runs, no port driven, drx reads 1.
        owr_i = 4'b0000;
        wr(32'h0005_0104);                       // edge 0
        bad  = (owr_e != 4'b0000 || owr_p != 4'b0000) ? 1 : 0;
        fall = -1;
        for (int e = 1; e <= 40; e++) begin
            tick();
            if (owr_e != 4'b0000 || owr_p != 4'b0000) bad++;
            if (fall < 0 && !avalon_readdata[10]) fall = e;
        end
        chk("sel5_busy_fall", 32'(fall), 32'd16);
        chk("sel5_no_drive", 32'(bad), 32'd0);
        chk("sel5_status", avalon_readdata, 32'h0005_003C);
        rd();
        chk("sel5_read_clear", avalon_readdata, 32'h0005_000C);

        // Reset asserted mid-cycle aborts without setting status.
        owr_i = 4'b1111;
        wr(32'h0001_0142);                       // edge 0
        for (int e = 1; e <= 5; e++) tick();
        chk("abort_pre_e", 32'(owr_e), 32'h2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_owr_e", 32'(owr_e), 32'h0);
        chk("abort_owr_p", 32'(owr_p), 32'h0);
        chk("abort_readdata", avalon_readdata, 32'h0);
        chk("abort_irq", 32'(avalon_interrupt), 32'h0);
        for (int e = 0; e < 300; e++) tick();
        chk("abort_no_status", avalon_readdata, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
